// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter in front of one simple-dual-port RAM.
// Grants are combinational. At most one RAM operation (read or write) is
// issued per cycle. Read data comes back one cycle after the read grant on
// a shared rdata bus, marked by rvalid0/rvalid1.
//
// Ownership FSM (IDLE / OWN0 / OWN1). The owner keeps the grant while it
// requests. When the other side is waiting, the owner is cut off after
// MAXBURST consecutive grants.
//
// Build option: define RAM_ARBITER_RR_EN to resolve an IDLE tie round-robin
// (the requester not served most recently wins). Leave it undefined for
// fixed priority, where requester 0 always wins the tie.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req0/1, we0/1             request valid, 1 = write / 0 = read
//   addr0/1, wdata0/1         request address and write data
//   gnt0/1                    combinational accept
//   rvalid0/1, rdata          read return, one cycle after the read grant
//   rden, rdaddr              RAM read port
//   wren, wraddr, wrdata      RAM write port
//   ram_rddata                RAM registered read data
module ram_arbiter #(
  parameter int WIDTH    = 64,
  parameter int SIZE     = 512,
  parameter int MAXBURST = 8,
  localparam int ABITS   = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [ABITS-1:0] addr0,
  input  logic [ABITS-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata,
  output logic             rden,
  output logic [ABITS-1:0] rdaddr,
  output logic             wren,
  output logic [ABITS-1:0] wraddr,
  output logic [WIDTH-1:0] wrdata,
  input  logic [WIDTH-1:0] ram_rddata
);

  localparam int CW = $clog2(MAXBURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAXBURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] burst_reg;
  logic          rvalid0_reg;
  logic          rvalid1_reg;
`ifdef RAM_ARBITER_RR_EN
  // One-hot "served most recently": bit n set means requester n was served
  // last. The reset value 2'b01 marks requester 0, so the first tie after
  // reset goes to requester 1.
  logic [1:0]    last_reg;
`endif

  logic grant0;
  logic grant1;
  logic burst_at_max;

  assign burst_at_max = (burst_reg == BURST_MAX);

  // Grant decision. Rst masks the grant outputs so that nothing can be
  // accepted while reset is held, whatever the requests are doing.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req0 && req1) begin
`ifdef RAM_ARBITER_RR_EN
          if (last_reg[1]) grant0 = 1'b1;
          else             grant1 = 1'b1;
`else
          grant0 = 1'b1;
`endif
        end else begin
          grant0 = req0;
          grant1 = req1;
        end
      end
      OWN0: begin
        if (req0 && !(burst_at_max && req1)) grant0 = 1'b1;
        else if (req1)                       grant1 = 1'b1;
      end
      OWN1: begin
        if (req1 && !(burst_at_max && req0)) grant1 = 1'b1;
        else if (req0)                       grant0 = 1'b1;
      end
      default: begin
        grant0 = 1'b0;
        grant1 = 1'b0;
      end
    endcase
  end

  assign gnt0 = grant0 & ~rst;
  assign gnt1 = grant1 & ~rst;

  // RAM port drive. The two grants are exclusive, so rden and wren can
  // never both be high.
  assign rden   = (gnt0 & ~we0) | (gnt1 & ~we1);
  assign wren   = (gnt0 &  we0) | (gnt1 &  we1);
  assign rdaddr = gnt1 ? addr1  : addr0;
  assign wraddr = gnt1 ? addr1  : addr0;
  assign wrdata = gnt1 ? wdata1 : wdata0;

  assign rvalid0 = rvalid0_reg;
  assign rvalid1 = rvalid1_reg;
  // Gate the shared read bus so that it reads zero whenever no return is
  // pending, including during reset.
  assign rdata   = (rvalid0_reg | rvalid1_reg) ? ram_rddata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      burst_reg   <= '0;
      rvalid0_reg <= 1'b0;
      rvalid1_reg <= 1'b0;
`ifdef RAM_ARBITER_RR_EN
      last_reg    <= 2'b01;
`endif
    end else begin
      rvalid0_reg <= gnt0 & ~we0;
      rvalid1_reg <= gnt1 & ~we1;
      if (gnt0) begin
        // A grant to the current owner extends its burst. A grant to a new
        // owner starts a new burst at 1.
        if (state_reg == OWN0)
          burst_reg <= burst_at_max ? burst_reg : burst_reg + CW'(1);
        else
          burst_reg <= CW'(1);
        state_reg <= OWN0;
`ifdef RAM_ARBITER_RR_EN
        last_reg  <= 2'b01;
`endif
      end else if (gnt1) begin
        if (state_reg == OWN1)
          burst_reg <= burst_at_max ? burst_reg : burst_reg + CW'(1);
        else
          burst_reg <= CW'(1);
        state_reg <= OWN1;
`ifdef RAM_ARBITER_RR_EN
        last_reg  <= 2'b10;
`endif
      end else begin
        state_reg <= IDLE;
        burst_reg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter (WIDTH=16, SIZE=16, MAXBURST=4).
// It holds a small behavioural RAM with registered read and drives directed
// vectors from a table. Hand-written sequences cover bursts, same-cycle
// read/write contention, the tie-break, and reset in the middle of a read.
// The run ends with a random two-requester stream that is checked against a
// reference memory. Expected values depend on RAM_ARBITER_RR_EN.
module tb_ram_arbiter;

  localparam int DW = 16;
  localparam int SZ = 16;
  localparam int AW = 4;
  localparam int MB = 4;
`ifdef RAM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          rden, wren;
  logic [AW-1:0] rdaddr, wraddr;
  logic [DW-1:0] wrdata;
  logic [DW-1:0] ram_rddata;

  int total = 0;
  int bad   = 0;

  ram_arbiter #(.WIDTH(DW), .SIZE(SZ), .MAXBURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .rden(rden), .rdaddr(rdaddr), .wren(wren),
    .wraddr(wraddr), .wrdata(wrdata), .ram_rddata(ram_rddata)
  );

  always #5 clk = ~clk;

  // Shared RAM with registered read.
  logic [DW-1:0] mem [SZ];
  always @(posedge clk) begin
    if (wren) mem[wraddr] <= wrdata;
    if (rden) ram_rddata <= mem[rdaddr];
  end

  typedef struct {
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          g0, g1, rd, wr, v0, v1;
    logic [DW-1:0] rdat;
  } vec_t;

  vec_t vecs[12];

  // Variables for the hand-written sequences and the random stream.
  logic          pg0, pg1, eg0, eg1;
  logic [DW-1:0] ref_mem [SZ];
  bit            ref_known [SZ];
  bit            pend0, pend1, prd0, prd1, pknown0, pknown1;
  logic [DW-1:0] pexp0, pexp1;
  int            wait0, wait1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic r0, input logic w0, input logic [AW-1:0] a0,
                        input logic [DW-1:0] d0, input logic r1, input logic w1,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Assert reset with both requests held high, check that every output is
  // forced low, then release reset in the middle of a cycle with the
  // requests already dropped.
  task automatic do_reset();
    set_in(1'b1, 1'b0, 4'd5, 16'h0, 1'b1, 1'b0, 4'd3, 16'h0);
    rst = 1'b1;
    #2;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_rden", rden, 0);
    chk("rst_wren", wren, 0);
    chk("rst_rvalid", {rvalid1, rvalid0}, 0);
    chk("rst_rdata", rdata, 0);
    @(posedge clk);
    #4;
    set_in(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0);
    rst = 1'b0;
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           r0    w0    a0    d0        r1    w1    a1    d1        g0    g1    rd    wr    v0    v1    rdata
    vecs[0]  = '{1'b1, 1'b1, 4'd5, 16'h00AA, 1'b0, 1'b0, 4'd0, 16'h0,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0};
    vecs[1]  = '{1'b1, 1'b0, 4'd5, 16'h0,    1'b0, 1'b0, 4'd0, 16'h0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
    vecs[2]  = '{1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00AA};
    vecs[3]  = '{1'b0, 1'b0, 4'd0, 16'h0,    1'b1, 1'b1, 4'd3, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0};
    vecs[4]  = '{1'b0, 1'b0, 4'd0, 16'h0,    1'b1, 1'b0, 4'd3, 16'h0,    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
    vecs[5]  = '{1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234};
    vecs[6]  = '{1'b1, 1'b0, 4'd5, 16'h0,    1'b1, 1'b0, 4'd3, 16'h0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
    vecs[7]  = '{1'b0, 1'b0, 4'd0, 16'h0,    1'b1, 1'b0, 4'd3, 16'h0,    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h00AA};
    vecs[8]  = '{1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234};
    vecs[9]  = '{1'b1, 1'b1, 4'd5, 16'h0055, 1'b1, 1'b0, 4'd5, 16'h0,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0};
    vecs[10] = '{1'b0, 1'b0, 4'd0, 16'h0,    1'b1, 1'b0, 4'd5, 16'h0,    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
    vecs[11] = '{1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 1'b0, 4'd0, 16'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0055};

    // Reset state, with requests held high to show that grants are masked.
    rst = 1'b1;
    set_in(1'b1, 1'b1, 4'd1, 16'h1, 1'b1, 1'b0, 4'd2, 16'h0);
    #3;
    chk("init_gnt0", gnt0, 0);
    chk("init_gnt1", gnt1, 0);
    chk("init_rden", rden, 0);
    chk("init_wren", wren, 0);
    chk("init_rvalid0", rvalid0, 0);
    chk("init_rvalid1", rvalid1, 0);
    chk("init_rdata", rdata, 0);
    #9;
    set_in(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0);
    rst = 1'b0;
    next_cycle();

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
             vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      #3;
      chk($sformatf("vec%0d_gnt0", i), gnt0, vecs[i].g0);
      chk($sformatf("vec%0d_gnt1", i), gnt1, vecs[i].g1);
      chk($sformatf("vec%0d_rden", i), rden, vecs[i].rd);
      chk($sformatf("vec%0d_wren", i), wren, vecs[i].wr);
      chk($sformatf("vec%0d_rvalid0", i), rvalid0, vecs[i].v0);
      chk($sformatf("vec%0d_rvalid1", i), rvalid1, vecs[i].v1);
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].rdat);
      $display("vec %0d: req=%b%b gnt=%b%b rden=%b wren=%b rvalid=%b%b rdata=%h",
               i, req1, req0, gnt1, gnt0, rden, wren, rvalid1, rvalid0, rdata);
      next_cycle();
    end

    // Burst limit: req0 holds from cycle 0 and req1 joins at cycle 1. Owner 0
    // gets cycles 0-3 and owner 1 gets cycles 4-7. At cycle 8 requester 0
    // takes the grant back because owner 1 has used up its burst.
    pg0 = 1'b0;
    pg1 = 1'b0;
    for (int c = 0; c < 9; c++) begin
      set_in(1'b1, 1'b0, 4'd5, 16'h0, (c >= 1), 1'b0, 4'd3, 16'h0);
      #3;
      eg0 = (c < 4) || (c == 8);
      eg1 = (c >= 4) && (c < 8);
      chk($sformatf("burst%0d_gnt0", c), gnt0, eg0);
      chk($sformatf("burst%0d_gnt1", c), gnt1, eg1);
      chk($sformatf("burst%0d_rvalid0", c), rvalid0, pg0);
      chk($sformatf("burst%0d_rvalid1", c), rvalid1, pg1);
      chk($sformatf("burst%0d_rdata", c), rdata, pg0 ? 16'h0055 : (pg1 ? 16'h1234 : 16'h0));
      $display("burst %0d: req=%b%b gnt=%b%b rvalid=%b%b rdata=%h",
               c, req1, req0, gnt1, gnt0, rvalid1, rvalid0, rdata);
      pg0 = eg0;
      pg1 = eg1;
      next_cycle();
    end
    set_in(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0);
    next_cycle();

    // Contention from IDLE after reset: req0 writes addr 3 while req1 reads
    // addr 3. Each requester drops its request once it has been served.
    do_reset();
    set_in(1'b1, 1'b1, 4'd3, 16'h0077, 1'b1, 1'b0, 4'd3, 16'h0);
    #3;
    chk("coll_gnt0", gnt0, !RR);
    chk("coll_gnt1", gnt1, RR);
    chk("coll_rden", rden, RR);
    chk("coll_wren", wren, !RR);
    chk("coll_excl", rden & wren, 0);
    $display("coll 0: gnt=%b%b rden=%b wren=%b", gnt1, gnt0, rden, wren);
    next_cycle();
    if (RR) set_in(1'b1, 1'b1, 4'd3, 16'h0077, 1'b0, 1'b0, 4'd0, 16'h0);
    else    set_in(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 4'd3, 16'h0);
    #3;
    chk("coll2_gnt0", gnt0, RR);
    chk("coll2_gnt1", gnt1, !RR);
    chk("coll2_wren", wren, RR);
    chk("coll2_rden", rden, !RR);
    chk("coll2_excl", rden & wren, 0);
    chk("coll2_rvalid1", rvalid1, RR);
    chk("coll2_rdata", rdata, RR ? 16'h1234 : 16'h0);
    $display("coll 1: gnt=%b%b rden=%b wren=%b rvalid1=%b rdata=%h", gnt1, gnt0, rden, wren, rvalid1, rdata);
    next_cycle();
    set_in(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0);
    #3;
    chk("coll3_rvalid0", rvalid0, 0);
    chk("coll3_rvalid1", rvalid1, !RR);
    chk("coll3_rdata", rdata, RR ? 16'h0 : 16'h0077);
    $display("coll 2: rvalid=%b%b rdata=%h", rvalid1, rvalid0, rdata);
    next_cycle();

    // Tie-break from IDLE with one-cycle requests from both sides.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 1'b0, 4'd5, 16'h0, 1'b1, 1'b0, 4'd3, 16'h0);
      #3;
      eg1 = RR && (k % 2 == 0);
      chk($sformatf("tie%0d_gnt1", k), gnt1, eg1);
      chk($sformatf("tie%0d_gnt0", k), gnt0, !eg1);
      $display("tie %0d: gnt=%b%b", k, gnt1, gnt0);
      next_cycle();
      set_in(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0);
      next_cycle();
    end

    // Reset in the middle of the cycle that follows a read grant.
    set_in(1'b1, 1'b0, 4'd5, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0);
    #3;
    chk("rstrd_gnt0", gnt0, 1);
    next_cycle();
    rst = 1'b1;
    #1;
    chk("rstrd_rvalid0", rvalid0, 0);
    chk("rstrd_rvalid1", rvalid1, 0);
    chk("rstrd_gnt0_masked", gnt0, 0);
    chk("rstrd_rden", rden, 0);
    chk("rstrd_wren", wren, 0);
    chk("rstrd_rdata", rdata, 0);
    next_cycle();
    chk("rstrd_rvalid0_held", rvalid0, 0);
    #4;
    rst = 1'b0;
    set_in(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 4'd3, 16'h0);
    #1;
    chk("rstrd_first_gnt1", gnt1, 1);
    chk("rstrd_first_rden", rden, 1);
    chk("rstrd_first_gnt0", gnt0, 0);
    next_cycle();
    chk("rstrd_after_rvalid0", rvalid0, 0);
    chk("rstrd_after_rvalid1", rvalid1, 1);
    chk("rstrd_after_rdata", rdata, 16'h0077);
    $display("rst-mid-read: rvalid=%b%b rdata=%h", rvalid1, rvalid0, rdata);
    set_in(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0);
    next_cycle();

    // Random stream against a reference memory. A requester keeps its
    // transaction stable until it is granted.
    for (int a = 0; a < SZ; a++) ref_known[a] = 1'b0;
    pend0 = 0; pend1 = 0; prd0 = 0; prd1 = 0; pknown0 = 0; pknown1 = 0;
    pexp0 = '0; pexp1 = '0; wait0 = 0; wait1 = 0;
    for (int c = 0; c < 150; c++) begin
      if (!pend0 && $urandom_range(0, 3) != 0) begin
        pend0 = 1'b1; we0 = 1'($urandom_range(0, 1));
        addr0 = AW'($urandom_range(0, SZ - 1)); wdata0 = DW'($urandom);
      end
      if (!pend1 && $urandom_range(0, 3) != 0) begin
        pend1 = 1'b1; we1 = 1'($urandom_range(0, 1));
        addr1 = AW'($urandom_range(0, SZ - 1)); wdata1 = DW'($urandom);
      end
      req0 = pend0;
      req1 = pend1;
      #3;
      chk("rnd_gnt0_noreq", gnt0 & ~req0, 0);
      chk("rnd_gnt1_noreq", gnt1 & ~req1, 0);
      chk("rnd_gnt_excl", gnt0 & gnt1, 0);
      chk("rnd_ram_excl", rden & wren, 0);
      chk("rnd_rvalid0", rvalid0, prd0);
      chk("rnd_rvalid1", rvalid1, prd1);
      if (prd0 && pknown0) chk("rnd_rdata0", rdata, pexp0);
      if (prd1 && pknown1) chk("rnd_rdata1", rdata, pexp1);
      $display("rnd %0d: req=%b%b we=%b%b gnt=%b%b rvalid=%b%b rdata=%h",
               c, req1, req0, we1, we0, gnt1, gnt0, rvalid1, rvalid0, rdata);
      prd0 = gnt0 & ~we0;
      prd1 = gnt1 & ~we1;
      if (prd0) begin pknown0 = ref_known[addr0]; pexp0 = ref_mem[addr0]; end
      if (prd1) begin pknown1 = ref_known[addr1]; pexp1 = ref_mem[addr1]; end
      if (gnt0 && we0) begin ref_mem[addr0] = wdata0; ref_known[addr0] = 1'b1; end
      if (gnt1 && we1) begin ref_mem[addr1] = wdata1; ref_known[addr1] = 1'b1; end
      if (gnt0) begin pend0 = 1'b0; wait0 = 0; end else if (pend0) wait0++;
      if (gnt1) begin pend1 = 1'b0; wait1 = 0; end else if (pend1) wait1++;
      chk("rnd_wait0_bound", (wait0 > MB), 0);
      chk("rnd_wait1_bound", (wait1 > MB), 0);
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data width matching the shared RAM.
REQ-002 SHALL have parameter SIZE, default 512, RAM depth in words; ABITS = $clog2(SIZE).
REQ-003 SHALL have parameter MAXBURST, default 8, maximum consecutive grants to one requester while the other waits.
REQ-004 SHALL have port clk  in  1  single clock for the arbiter and both RAM ports.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports req0/req1  in  1  requester n holds a valid request.
REQ-007 SHALL have ports we0/we1  in  1  1 = write, 0 = read; stable while reqn is high.
REQ-008 SHALL have ports addr0/addr1  in  ABITS  request address.
REQ-009 SHALL have ports wdata0/wdata1  in  WIDTH  write data.
REQ-010 SHALL have ports gnt0/gnt1  out  1  combinational accept; the transfer occurs when reqn and gntn are both high.
REQ-011 SHALL have ports rvalid0/rvalid1  out  1  read data valid for requester n.
REQ-012 SHALL have port rdata  out  WIDTH  read data, shared; qualified by rvalid0 or rvalid1.
REQ-013 SHALL have RAM-side ports rden, rdaddr[ABITS], wren, wraddr[ABITS], wrdata[WIDTH]  out, plus ram_rddata[WIDTH]  in.

Function
REQ-014 SHALL issue at most one RAM operation per cycle; rden and wren are never high together, so RAM read-priority collisions cannot occur.
REQ-015 SHALL assert at most one of gnt0/gnt1 per cycle, and gntn only while reqn is high.
REQ-016 SHALL drive rden/rdaddr or wren/wraddr/wrdata combinationally from the granted requester in the grant cycle.
REQ-017 SHALL assert rvalidn exactly one cycle after a granted read by requester n; rdata = ram_rddata in that cycle.
REQ-018 SHALL hold rvalid0/rvalid1 low after a granted write.
REQ-019 SHALL implement FSM states IDLE, OWN0 and OWN1: IDLE->OWNn on a grant to n; OWNn->OWNm or IDLE according to REQ-020 to REQ-022.
REQ-020 In OWNn, SHALL keep granting n while reqn is high, unless the burst count has reached MAXBURST and reqm is high; in that case the grant switches to m, the state becomes OWNm and the count resets to 1.
REQ-021 SHALL count consecutive grants to the owner, saturate the count at MAXBURST, and reset it on an ownership change.
REQ-022 In OWNn with reqn low, SHALL grant m in the same cycle if reqm is high (state becomes OWNm), else return to IDLE.
REQ-023 In IDLE with both requesting, SHALL choose per REQ-030/REQ-031.
REQ-024 With MAXBURST=1, SHALL alternate grants every cycle while both requesters are active.

Reset
REQ-025 While rst is high, SHALL force gnt0=gnt1=0, rvalid0=rvalid1=0, rden=wren=0, rdata=0, state=IDLE, burst count=0 and last-served=1, regardless of clk.
REQ-026 A read granted in the cycle before rst asserts SHALL NOT produce rvalid after reset.
REQ-027 SHALL accept its first grant in the first clk edge after rst deasserts.

Configuration
REQ-028 SHALL select the IDLE tie-break policy with the macro RAM_ARBITER_RR_EN.
REQ-029 The tie-break SHALL apply only in IDLE when req0 and req1 are both high.
REQ-030 With RAM_ARBITER_RR_EN defined, SHALL grant the requester not served most recently (round-robin).
REQ-031 With RAM_ARBITER_RR_EN undefined, SHALL always grant requester 0 (fixed priority); burst limiting per REQ-020 still applies.

Verification
REQ-032 Bench SHALL cover: req0 write addr 5 data 0xAA, then req0 read addr 5 -> gnt0 each cycle; rvalid0 one cycle after the read with rdata=0xAA; rvalid1=0.
REQ-033 Bench SHALL cover: req1 read addr 3 while req0 writes addr 3 in the same cycle (both from IDLE, RR, after reset) -> gnt1 first; rden only, never wren and rden together; write completes the next cycle.
REQ-034 Bench SHALL cover: MAXBURST=4, req0 continuous from cycle 0, req1 raised at cycle 1 -> gnt0 in cycles 0-3, gnt1 in cycle 4.
REQ-035 Bench SHALL cover: RR undefined, both requesting from IDLE repeatedly with single-cycle requests -> gnt0 every time; RR defined -> grants alternate 1,0,1,0.
REQ-036 Bench SHALL cover: rst pulsed mid-cycle one cycle after a read grant -> rvalid stays 0, all outputs 0 immediately, state IDLE.
REQ-037 Bench SHALL cover: a random two-requester stream against a reference memory model -> every read returns the last data written to its address, and gnt is never high without the matching req.
